id_ex_stage: RTL and testbench

- Pipeline register between instruction decode (register-file read) and execute in the 5-stage RV32I core.
- Captures the decoded operands, immediate, PC and control bundle each cycle.
- Detects load-use hazards against the instruction currently in EX and inserts one bubble per hazard.
- While held by an external stall, snoops writeback so held operands never go stale; counts inserted bubbles.

---
 rtl/id_ex_stage.sv | 122 ++++++++++++
 tb/tb_id_ex_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core, with load-use hazard detection and bubble counting.
// Latency: one cycle from ID to EX; hazard_o is combinational in the same cycle as the dependent ID instruction.
// Backpressure: stall_i holds every field (writeback is snooped into held operands); flush_i beats stall_i.
//
// Ports:
//   clk_i, rst_i (async, active-low)        clock and reset
//   stall_i, flush_i                        hold stage / kill the instruction being loaded
//   valid_i, pc_i, RS*addr_i, RDaddr_i,
//   rs*_used_i, RS*data_i, imm_i, ctrl_i    decoded ID instruction
//   wb_we_i, wb_rd_i, wb_data_i             writeback port, snooped only while stalled
//   valid_o, pc_o, imm_o, RS*data_o,
//   RS*addr_o, RDaddr_o, ctrl_o             registered EX copies (ctrl_o is zero when valid_o=0)
//   hazard_o                                stall PC and IF/ID this cycle
//   bubble_cnt_o                            load-use bubbles inserted since reset (wraps)
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [4:0]        RS1addr_i,
    input  logic [4:0]        RS2addr_i,
    input  logic [4:0]        RDaddr_i,
    input  logic              rs1_used_i,
    input  logic              rs2_used_i,
    input  logic [XLEN-1:0]   RS1data_i,
    input  logic [XLEN-1:0]   RS2data_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              wb_we_i,
    input  logic [4:0]        wb_rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic              valid_o,
    output logic [XLEN-1:0]   pc_o,
    output logic [XLEN-1:0]   imm_o,
    output logic [XLEN-1:0]   RS1data_o,
    output logic [XLEN-1:0]   RS2data_o,
    output logic [4:0]        RS1addr_o,
    output logic [4:0]        RS2addr_o,
    output logic [4:0]        RDaddr_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              hazard_o,
    output logic [31:0]       bubble_cnt_o
);

    // ctrl bit 2 is MemRead: the instruction in EX is a load.
    localparam int MEMREAD_BIT = 2;

    logic ex_is_load;
    logic rs1_dep;
    logic rs2_dep;
    logic snoop_rs1;
    logic snoop_rs2;

    assign ex_is_load = valid_o & ctrl_o[MEMREAD_BIT] & (RDaddr_o != 5'd0);
    assign rs1_dep    = rs1_used_i & (RS1addr_i == RDaddr_o);
    assign rs2_dep    = rs2_used_i & (RS2addr_i == RDaddr_o);

    // A downstream stall freezes EX anyway, so the hazard is irrelevant then;
    // suppressing it keeps the bubble from being counted while frozen.
    assign hazard_o = ex_is_load & valid_i & (rs1_dep | rs2_dep) & ~stall_i;

    // Held operands must track writes that retire while we wait, otherwise
    // the instruction would execute with a value the register file no longer holds.
    assign snoop_rs1 = valid_o & wb_we_i & (wb_rd_i != 5'd0) & (wb_rd_i == RS1addr_o);
    assign snoop_rs2 = valid_o & wb_we_i & (wb_rd_i != 5'd0) & (wb_rd_i == RS2addr_o);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_o      <= 1'b0;
            pc_o         <= '0;
            imm_o        <= '0;
            RS1data_o    <= '0;
            RS2data_o    <= '0;
            RS1addr_o    <= '0;
            RS2addr_o    <= '0;
            RDaddr_o     <= '0;
            ctrl_o       <= '0;
            bubble_cnt_o <= '0;
        end else if (flush_i) begin
            // Kill the instruction; data fields load normally since they are dead anyway.
            valid_o   <= 1'b0;
            ctrl_o    <= '0;
            pc_o      <= pc_i;
            imm_o     <= imm_i;
            RS1data_o <= RS1data_i;
            RS2data_o <= RS2data_i;
            RS1addr_o <= RS1addr_i;
            RS2addr_o <= RS2addr_i;
            RDaddr_o  <= RDaddr_i;
        end else if (stall_i) begin
            if (snoop_rs1) begin
                RS1data_o <= wb_data_i;
            end
            if (snoop_rs2) begin
                RS2data_o <= wb_data_i;
            end
        end else if (hazard_o) begin
            // Insert one bubble; the dependent instruction is held upstream
            // and reloads next cycle once the load has left EX.
            valid_o      <= 1'b0;
            ctrl_o       <= '0;
            bubble_cnt_o <= bubble_cnt_o + 32'd1;
        end else begin
            // RS*data_i is already bypassed by the register file for same-cycle WB.
            valid_o   <= valid_i;
            ctrl_o    <= valid_i ? ctrl_i : '0;
            pc_o      <= pc_i;
            imm_o     <= imm_i;
            RS1data_o <= RS1data_i;
            RS2data_o <= RS2data_i;
            RS1addr_o <= RS1addr_i;
            RS2addr_o <= RS2addr_i;
            RDaddr_o  <= RDaddr_i;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a reference model predicts the EX
// contents for each edge, pushes them to a scoreboard queue, and the
// prediction is popped and compared just after the edge.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i, flush_i, valid_i;
    logic [31:0] pc_i, RS1data_i, RS2data_i, imm_i, wb_data_i;
    logic [4:0]  RS1addr_i, RS2addr_i, RDaddr_i, wb_rd_i;
    logic        rs1_used_i, rs2_used_i, wb_we_i;
    logic [7:0]  ctrl_i;

    logic        valid_o, hazard_o;
    logic [31:0] pc_o, imm_o, RS1data_o, RS2data_o, bubble_cnt_o;
    logic [4:0]  RS1addr_o, RS2addr_o, RDaddr_o;
    logic [7:0]  ctrl_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        valid;
        logic [7:0]  ctrl;
        logic [31:0] pc, imm, d1, d2, cnt;
        logic [4:0]  a1, a2, rd;
        logic        dknown;   // data/address fields are defined (not don't-care)
    } st_t;

    st_t m;
    st_t sb_q[$];

    id_ex_stage #(.XLEN(32), .CTRL_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .pc_i(pc_i), .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i),
        .RDaddr_i(RDaddr_i), .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
        .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .imm_i(imm_i), .ctrl_i(ctrl_i),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .valid_o(valid_o), .pc_o(pc_o), .imm_o(imm_o), .RS1data_o(RS1data_o),
        .RS2data_o(RS2data_o), .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o),
        .RDaddr_o(RDaddr_o), .ctrl_o(ctrl_o), .hazard_o(hazard_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic st_t reset_state();
        st_t r;
        r.valid = 1'b0; r.ctrl = '0; r.pc = '0; r.imm = '0; r.d1 = '0; r.d2 = '0;
        r.cnt = '0; r.a1 = '0; r.a2 = '0; r.rd = '0; r.dknown = 1'b1;
        return r;
    endfunction

    function automatic logic model_hz(st_t s);
        logic dep;
        dep = (rs1_used_i && RS1addr_i == s.rd) || (rs2_used_i && RS2addr_i == s.rd);
        return s.valid && s.ctrl[2] && s.rd != 5'd0 && valid_i && dep && !stall_i;
    endfunction

    function automatic st_t model_next(st_t s);
        st_t n;
        n = s;
        if (flush_i || (!stall_i && !model_hz(s))) begin
            n.pc = pc_i; n.imm = imm_i; n.d1 = RS1data_i; n.d2 = RS2data_i;
            n.a1 = RS1addr_i; n.a2 = RS2addr_i; n.rd = RDaddr_i; n.dknown = 1'b1;
            n.valid = flush_i ? 1'b0 : valid_i;
            n.ctrl  = (flush_i || !valid_i) ? 8'h00 : ctrl_i;
        end else if (stall_i) begin
            if (s.valid && wb_we_i && wb_rd_i != 5'd0) begin
                if (wb_rd_i == s.a1) n.d1 = wb_data_i;
                if (wb_rd_i == s.a2) n.d2 = wb_data_i;
            end
        end else begin
            n.valid = 1'b0; n.ctrl = 8'h00; n.cnt = s.cnt + 32'd1; n.dknown = 1'b0;
        end
        return n;
    endfunction

    // One clock: check combinational hazard, predict, clock, compare.
    task automatic step(input string tag);
        st_t e;
        #1;
        chk({tag, ".hazard"}, {31'd0, hazard_o}, {31'd0, model_hz(m)});
        sb_q.push_back(model_next(m));
        @(posedge clk_i);
        #1;
        e = sb_q.pop_front();
        m = e;
        chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, e.valid});
        chk({tag, ".ctrl"}, {24'd0, ctrl_o}, {24'd0, e.ctrl});
        chk({tag, ".cnt"}, bubble_cnt_o, e.cnt);
        if (e.dknown) begin
            chk({tag, ".pc"}, pc_o, e.pc);
            chk({tag, ".imm"}, imm_o, e.imm);
            chk({tag, ".rs1d"}, RS1data_o, e.d1);
            chk({tag, ".rs2d"}, RS2data_o, e.d2);
            chk({tag, ".addr"}, {17'd0, RS1addr_o, RS2addr_o, RDaddr_o}, {17'd0, e.a1, e.a2, e.rd});
        end
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] rd, input logic u1,
                          input logic u2, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [7:0] ctrl);
        valid_i = v; pc_i = pc; RS1addr_i = a1; RS2addr_i = a2; RDaddr_i = rd;
        rs1_used_i = u1; rs2_used_i = u2; RS1data_i = d1; RS2data_i = d2;
        imm_i = imm; ctrl_i = ctrl;
    endtask

    task automatic set_ctl(input logic st, input logic fl, input logic we,
                           input logic [4:0] rd, input logic [31:0] d);
        stall_i = st; flush_i = fl; wb_we_i = we; wb_rd_i = rd; wb_data_i = d;
    endtask

    initial begin
        set_ctl(0, 0, 0, 0, 0);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b0;
        m = reset_state();
        #12;
        chk("reset.valid", {31'd0, valid_o}, 32'd0);
        chk("reset.cnt", bubble_cnt_o, 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        // Pass-through
        set_id(1, 32'h100, 5'd1, 5'd2, 5'd3, 1, 1, 32'h1234, 32'h5678, 32'hFFFFFFF0, 8'h11);
        step("pass");
        chk("pass.rs1d_lit", RS1data_o, 32'h1234);
        chk("pass.imm_lit", imm_o, 32'hFFFFFFF0);

        // Load-use: lw x5 into EX, then add x6,x5,x7
        set_id(1, 32'h104, 5'd2, 5'd0, 5'd5, 1, 0, 32'h40, 0, 32'h8, 8'h07);
        step("lw");
        set_id(1, 32'h108, 5'd5, 5'd7, 5'd6, 1, 1, 32'hAA, 32'hBB, 0, 8'h21);
        #1 chk("lu.hazard_lit", {31'd0, hazard_o}, 32'd1);
        step("lu_bubble");
        chk("lu.cnt_lit", bubble_cnt_o, 32'd1);
        step("lu_reload");
        chk("lu.reload_valid_lit", {31'd0, valid_o}, 32'd1);

        // Load to x0 must not raise a hazard
        set_id(1, 32'h10C, 5'd2, 5'd0, 5'd0, 1, 0, 0, 0, 0, 8'h07);
        step("lw_x0");
        set_id(1, 32'h110, 5'd0, 5'd0, 5'd6, 1, 1, 0, 0, 0, 8'h21);
        #1 chk("x0.hazard_lit", {31'd0, hazard_o}, 32'd0);
        step("x0_dep");

        // Hazard suppressed while stalled, then raised once the stall drops
        set_id(1, 32'h114, 5'd1, 5'd0, 5'd4, 1, 0, 0, 0, 0, 8'h07);
        step("lw_x4");
        set_id(1, 32'h118, 5'd3, 5'd4, 5'd8, 1, 1, 0, 0, 0, 8'h21);
        set_ctl(1, 0, 0, 0, 0);
        step("stall_hz");
        set_ctl(0, 0, 0, 0, 0);
        step("hz_after_stall");
        step("reload_after_stall");

        // Stall snoop
        set_id(1, 32'h200, 5'd8, 5'd9, 5'd10, 1, 1, 32'h11, 32'h22, 32'h4, 8'h11);
        step("snoop_load");
        set_id(1, 32'h204, 5'd1, 5'd1, 5'd1, 1, 1, 32'h99, 32'h99, 32'h0, 8'h33);
        set_ctl(1, 0, 1, 5'd9, 32'hDEADBEEF);
        step("snoop_rs2");
        chk("snoop.rs2_lit", RS2data_o, 32'hDEADBEEF);
        chk("snoop.rs1_hold_lit", RS1data_o, 32'h11);
        set_ctl(1, 0, 1, 5'd0, 32'h55555555);
        step("snoop_x0");
        set_ctl(1, 0, 1, 5'd8, 32'hCAFEF00D);
        step("snoop_rs1");
        set_ctl(1, 0, 0, 5'd9, 32'h12345678);
        step("snoop_nowe");

        // Flush beats stall
        set_ctl(1, 1, 1, 5'd9, 32'h0BADF00D);
        step("flush_stall");
        set_ctl(0, 0, 0, 0, 0);

        // lw x5 ; lw x6,0(x5) ; add x7,x6,x1
        set_id(1, 32'h300, 5'd1, 5'd0, 5'd5, 1, 0, 0, 0, 0, 8'h07);
        step("chain_lw1");
        set_id(1, 32'h304, 5'd5, 5'd0, 5'd6, 1, 0, 0, 0, 0, 8'h07);
        step("chain_b1");
        step("chain_lw2");
        set_id(1, 32'h308, 5'd1, 5'd6, 5'd7, 1, 1, 0, 0, 0, 8'h21);
        step("chain_b2");
        step("chain_add");
        chk("chain.cnt_lit", bubble_cnt_o, 32'd4);

        // Asynchronous reset mid-cycle with valid_o=1
        #3 rst_i = 1'b0;
        #1;
        chk("areset.valid", {31'd0, valid_o}, 32'd0);
        chk("areset.ctrl", {24'd0, ctrl_o}, 32'd0);
        chk("areset.cnt", bubble_cnt_o, 32'd0);
        @(posedge clk_i); #1;
        chk("areset.hold_valid", {31'd0, valid_o}, 32'd0);
        m = reset_state();
        #2 rst_i = 1'b1;

        // Random traffic over a small register set
        for (int i = 0; i < 300; i++) begin
            set_id($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom, $urandom, $urandom,
                   ($urandom_range(0, 1) != 0) ? 8'h07 : 8'($urandom));
            set_ctl($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 1), $urandom_range(0, 3), $urandom);
            step("rand");
        end
        set_ctl(0, 0, 0, 0, 0);

        // Counter wrap
        set_id(1, 32'h400, 5'd1, 5'd0, 5'd5, 1, 0, 0, 0, 0, 8'h07);
        step("wrap_lw");
        force dut.bubble_cnt_o = 32'hFFFFFFFF;
        #1 release dut.bubble_cnt_o;
        m.cnt = 32'hFFFFFFFF;
        chk("wrap.preload", bubble_cnt_o, 32'hFFFFFFFF);
        set_id(1, 32'h404, 5'd0, 5'd5, 5'd6, 0, 1, 0, 0, 0, 8'h21);
        step("wrap_hz");
        chk("wrap.zero_lit", bubble_cnt_o, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
